// File: rtl/quadrature_generator_if.sv
// Command channel of the quadrature generator: a valid/ready step request
// carrying direction and step count.
interface quadrature_generator_if #(
    parameter int STEP_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_dir;
    logic [STEP_W-1:0] cmd_steps;

    modport master (
        output cmd_valid,
        output cmd_dir,
        output cmd_steps,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_dir,
        input  cmd_steps,
        output cmd_ready
    );
endinterface

// File: rtl/quadrature_generator.sv
// Emits two-phase Gray-coded A/B waveforms for a commanded number of steps at a
// fixed dwell per state, and tracks the net position emitted since reset.
module quadrature_generator #(
    parameter int PHASE_CLKS     = 4,
    parameter int EDGES_PER_STEP = 4,
    parameter int STEP_W         = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    quadrature_generator_if.slave      cmd,
    output logic                       quad_A,
    output logic                       quad_B,
    output logic                       busy,
    output logic                       done,
    output logic [STEP_W-1:0]          position
);

    localparam int CNT_W  = (PHASE_CLKS > 1) ? $clog2(PHASE_CLKS) : 1;
    localparam int EDGE_W = STEP_W + 2;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(PHASE_CLKS - 1);
    localparam logic [1:0]       SUB_LAST   = 2'(EDGES_PER_STEP - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVE      = 2'd1,
        ST_DWELL_END = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    dwell_q, dwell_d;
    logic [EDGE_W-1:0]   edges_q, edges_d;
    logic [1:0]          sub_q, sub_d;
    logic                dir_q, dir_d;
    logic [1:0]          phase_q, phase_d;
    logic                quad_a_q, quad_a_d;
    logic                quad_b_q, quad_b_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [STEP_W-1:0]   position_q, position_d;
    logic [1:0]          ab_s;
    logic                accept_s;
    logic                dwell_end_s;

    // Phase index to (A,B): 0=00, 1=10, 2=11, 3=01; CW walks the index up.
    function automatic logic [1:0] gray_ab(input logic [1:0] idx);
        logic [1:0] ab;
        case (idx)
            2'd0:    ab = 2'b00;
            2'd1:    ab = 2'b10;
            2'd2:    ab = 2'b11;
            2'd3:    ab = 2'b01;
            default: ab = 2'b00;
        endcase
        return ab;
    endfunction

    // Next-state, counters, Gray phase and registered output values.
    always_comb begin
        state_d    = state_q;
        dwell_d    = dwell_q;
        edges_d    = edges_q;
        sub_d      = sub_q;
        dir_d      = dir_q;
        phase_d    = phase_q;
        position_d = position_q;
        accept_s    = cmd.cmd_valid & ready_q;
        dwell_end_s = (dwell_q == DWELL_LAST);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    dir_d   = cmd.cmd_dir;
                    edges_d = EDGE_W'(cmd.cmd_steps) * EDGE_W'(EDGES_PER_STEP);
                    sub_d   = 2'd0;
                    if (cmd.cmd_steps != {STEP_W{1'b0}}) begin
                        state_d = ST_MOVE;
                        dwell_d = {CNT_W{1'b0}};
                    end else begin
                        // Zero steps: a one-clock tail so done follows the accept edge by one cycle.
                        state_d = ST_DWELL_END;
                        dwell_d = DWELL_LAST;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MOVE: begin
                if (dwell_end_s) begin
                    dwell_d = {CNT_W{1'b0}};
                    phase_d = dir_q ? (phase_q + 2'd1) : (phase_q - 2'd1);
                    edges_d = edges_q - EDGE_W'(1);
                    if (sub_q == SUB_LAST) begin
                        sub_d      = 2'd0;
                        position_d = dir_q ? (position_q + STEP_W'(1)) : (position_q - STEP_W'(1));
                    end else begin
                        sub_d = sub_q + 2'd1;
                    end
                    if (edges_q == EDGE_W'(1)) begin
                        state_d = ST_DWELL_END;
                    end else begin
                        state_d = ST_MOVE;
                    end
                end else begin
                    dwell_d = dwell_q + CNT_W'(1);
                end
            end
            ST_DWELL_END: begin
                if (dwell_end_s) begin
                    dwell_d = {CNT_W{1'b0}};
                    state_d = ST_DONE;
                end else begin
                    dwell_d = dwell_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ab_s     = gray_ab(phase_d);
        quad_a_d = ab_s[1];
        quad_b_d = ab_s[0];
        ready_d  = (state_d == ST_IDLE) || (state_d == ST_DONE);
        busy_d   = ~ready_d;
        done_d   = (state_d == ST_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            dwell_q    <= {CNT_W{1'b0}};
            edges_q    <= {EDGE_W{1'b0}};
            sub_q      <= 2'd0;
            dir_q      <= 1'b0;
            phase_q    <= 2'd0;
            quad_a_q   <= 1'b0;
            quad_b_q   <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            position_q <= {STEP_W{1'b0}};
        end else begin
            state_q    <= state_d;
            dwell_q    <= dwell_d;
            edges_q    <= edges_d;
            sub_q      <= sub_d;
            dir_q      <= dir_d;
            phase_q    <= phase_d;
            quad_a_q   <= quad_a_d;
            quad_b_q   <= quad_b_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            position_q <= position_d;
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign quad_A        = quad_a_q;
    assign quad_B        = quad_b_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign position      = position_q;

endmodule

// File: tb/tb_quadrature_generator.sv
// Randomised bench for quadrature_generator; a timeline model derives expected
// A/B, position and handshake values from each command's accept edge.
module tb_quadrature_generator;

    localparam int P  = 4;
    localparam int E  = 4;
    localparam int SW = 8;

    typedef struct {
        bit dir;
        int steps;
    } cmd_t;

    logic          clk;
    logic          rst;
    logic          quad_A;
    logic          quad_B;
    logic          busy;
    logic          done;
    logic [SW-1:0] position;

    quadrature_generator_if #(.STEP_W(SW)) cmd_if ();

    quadrature_generator #(
        .PHASE_CLKS    (P),
        .EDGES_PER_STEP(E),
        .STEP_W        (SW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cmd     (cmd_if.slave),
        .quad_A  (quad_A),
        .quad_B  (quad_B),
        .busy    (busy),
        .done    (done),
        .position(position)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cmd_t       cmd_q[$];
    int         n_checks;
    int         n_fail;
    int         edge_n;
    bit         m_active;
    bit         m_dir;
    int         m_t;
    int         m_n;
    int         m_phase;
    int         m_pos;
    bit         exp_ready;
    logic [1:0] gray_tbl [4];

    // Count one comparison and report it when it disagrees.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got=%0d expected=%0d", tag, edge_n, got, exp);
        end
    endtask

    // One clock: drive inputs, let the edge happen, update the model, compare at negedge.
    task automatic tick();
        bit         acc;
        int         el, tot, fin, tr, ph, pos;
        bit         e_done, e_rdy;
        logic [1:0] ab;
        if (cmd_q.size() > 0) begin
            cmd_if.cmd_valid = 1'b1;
            if (exp_ready) begin
                cmd_if.cmd_dir   = cmd_q[0].dir;
                cmd_if.cmd_steps = SW'(cmd_q[0].steps);
            end else begin
                cmd_if.cmd_dir   = 1'($urandom);
                cmd_if.cmd_steps = SW'($urandom);
            end
        end else begin
            cmd_if.cmd_valid = 1'b0;
            cmd_if.cmd_dir   = 1'($urandom);
            cmd_if.cmd_steps = SW'($urandom);
        end
        acc = cmd_if.cmd_valid && exp_ready && !rst;

        @(posedge clk);
        edge_n++;
        if (rst) begin
            m_active = 1'b0;
            m_phase  = 0;
            m_pos    = 0;
        end else if (acc) begin
            m_active = 1'b1;
            m_t      = edge_n;
            m_dir    = cmd_q[0].dir;
            m_n      = cmd_q[0].steps;
            void'(cmd_q.pop_front());
        end

        @(negedge clk);
        if (m_active) begin
            el     = edge_n - m_t;
            tot    = m_n * E;
            fin    = (m_n == 0) ? 1 : (tot + 1) * P;
            tr     = (el / P < tot) ? el / P : tot;
            ph     = (((m_phase + (m_dir ? tr : -tr)) % 4) + 4) % 4;
            pos    = (m_pos + (m_dir ? tr / E : -(tr / E))) & 255;
            e_done = (el == fin);
            e_rdy  = (el >= fin);
        end else begin
            el     = 0;
            fin    = 0;
            ph     = m_phase;
            pos    = m_pos;
            e_done = 1'b0;
            e_rdy  = 1'b1;
        end
        ab = gray_tbl[ph];
        check_eq("quad_A",    32'(quad_A),           32'(ab[1]));
        check_eq("quad_B",    32'(quad_B),           32'(ab[0]));
        check_eq("position",  32'(position),         32'(pos));
        check_eq("done",      32'(done),             32'(e_done));
        check_eq("cmd_ready", 32'(cmd_if.cmd_ready), 32'(e_rdy));
        check_eq("busy",      32'(busy),             32'(!e_rdy));
        exp_ready = e_rdy;
        if (m_active && el >= fin) begin
            m_phase  = ph;
            m_pos    = pos;
            m_active = 1'b0;
        end
    endtask

    task automatic push(input bit dir, input int steps);
        cmd_t c;
        c.dir   = dir;
        c.steps = steps;
        cmd_q.push_back(c);
    endtask

    // Tick until all queued commands have run to completion, within a cycle budget.
    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((cmd_q.size() > 0 || m_active) && k < budget) begin
            tick();
            k++;
        end
        check_eq("drain_timeout", 32'(k < budget), 32'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        edge_n    = 0;
        m_active  = 1'b0;
        m_phase   = 0;
        m_pos     = 0;
        exp_ready = 1'b1;
        gray_tbl[0] = 2'b00;
        gray_tbl[1] = 2'b10;
        gray_tbl[2] = 2'b11;
        gray_tbl[3] = 2'b01;
        rst              = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_dir   = 1'b0;
        cmd_if.cmd_steps = '0;
        @(negedge clk);

        // Reset held for five cycles.
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b0;
        tick();

        // One CW step, then a zero-step command.
        push(1'b1, 1);
        drain(200);
        tick();
        push(1'b0, 0);
        drain(50);
        tick();

        // Reset ten clocks into a three-step CW command.
        push(1'b1, 3);
        for (int i = 0; i < 8 && !m_active; i++) tick();
        check_eq("rst_cmd_started", 32'(m_active), 32'd1);
        while (m_active && edge_n < m_t + 9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // CCW from zero wraps the position to 255.
        push(1'b0, 1);
        drain(200);
        check_eq("ccw_wrap", 32'(position), 32'd255);

        // Two commands queued together run back-to-back.
        push(1'b1, 2);
        push(1'b0, 1);
        drain(400);

        // Randomised commands, occasional back-to-back pairs and mid-command resets.
        for (int i = 0; i < 40; i++) begin
            push(1'($urandom), int'($urandom_range(0, 5)));
            if ($urandom_range(0, 2) == 0) push(1'($urandom), int'($urandom_range(0, 3)));
            if (i % 10 == 7) begin
                for (int j = 0; j < int'($urandom_range(1, 30)); j++) tick();
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            drain(2000);
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) tick();
        end

        // A long CW run wraps position upward.
        push(1'b1, 255);
        drain(5000);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
